// File: rtl/alu_exec_pipe.sv
// Three-stage integer execute pipeline (ISSUE -> EX -> WB) with an owned register file and
// WB->EX bypass. Define ALU_SHIFT_EN to build the shifter; otherwise ops 5-7 retire as illegal.
module alu_exec_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic            in_use_imm,
    input  logic [AW-1:0]   in_rd,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic            stall,
    input  logic            flush,
    output logic            ret_valid,
    output logic [AW-1:0]   ret_rd,
    output logic [XLEN-1:0] ret_data,
    output logic            ret_ill,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
`ifdef ALU_SHIFT_EN
    localparam int unsigned SW = $clog2(XLEN);
`endif

    logic            ex_valid_q, ex_valid_d;
    logic [2:0]      ex_op_q, ex_op_d;
    logic            ex_use_imm_q, ex_use_imm_d;
    logic [AW-1:0]   ex_rd_q, ex_rd_d;
    logic [AW-1:0]   ex_rs1_q, ex_rs1_d;
    logic [AW-1:0]   ex_rs2_q, ex_rs2_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;

    logic            wb_valid_q, wb_valid_d;
    logic [AW-1:0]   wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            wb_ill_q, wb_ill_d;

    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];

    logic [XLEN-1:0] src1, src2, arg2, alu_res;
    logic            alu_ill;
    logic            wb_fwd_ok;

    // Illegal results never forward; x0 always reads zero even if WB targets it.
    assign wb_fwd_ok = wb_valid_q && !wb_ill_q;

    always_comb begin
        src1 = '0;
        src2 = '0;
        if (ex_rs1_q != '0) begin
            src1 = (wb_fwd_ok && wb_rd_q == ex_rs1_q) ? wb_data_q : rf_q[ex_rs1_q];
        end
        if (ex_rs2_q != '0) begin
            src2 = (wb_fwd_ok && wb_rd_q == ex_rs2_q) ? wb_data_q : rf_q[ex_rs2_q];
        end
        arg2 = ex_use_imm_q ? ex_imm_q : src2;
    end

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (ex_op_q)
            3'd0: alu_res = src1 + arg2;
            3'd1: alu_res = src1 - arg2;
            3'd2: alu_res = src1 ^ arg2;
            3'd3: alu_res = src1 | arg2;
            3'd4: alu_res = src1 & arg2;
`ifdef ALU_SHIFT_EN
            3'd5: alu_res = src1 << arg2[SW-1:0];
            3'd6: alu_res = src1 >> arg2[SW-1:0];
            3'd7: alu_res = $unsigned($signed(src1) >>> arg2[SW-1:0]);
`else
            3'd5, 3'd6, 3'd7: alu_ill = 1'b1;
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_op_d      = ex_op_q;
        ex_use_imm_d = ex_use_imm_q;
        ex_rd_d      = ex_rd_q;
        ex_rs1_d     = ex_rs1_q;
        ex_rs2_d     = ex_rs2_q;
        ex_imm_d     = ex_imm_q;
        wb_valid_d   = wb_valid_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        wb_ill_d     = wb_ill_q;
        rf_d         = rf_q;
        if (!stall) begin
            ex_valid_d   = in_valid;
            ex_op_d      = in_op;
            ex_use_imm_d = in_use_imm;
            ex_rd_d      = in_rd;
            ex_rs1_d     = in_rs1;
            ex_rs2_d     = in_rs2;
            ex_imm_d     = in_imm;
            // Flush kills the op leaving EX; the one being issued this edge survives.
            wb_valid_d   = ex_valid_q && !flush;
            wb_rd_d      = ex_rd_q;
            wb_data_d    = alu_res;
            wb_ill_d     = alu_ill;
            if (wb_valid_q && wb_rd_q != '0 && !wb_ill_q) begin
                rf_d[wb_rd_q] = wb_data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_op_q      <= '0;
            ex_use_imm_q <= 1'b0;
            ex_rd_q      <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_imm_q     <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            wb_ill_q     <= 1'b0;
            rf_q         <= '{default: '0};
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_op_q      <= ex_op_d;
            ex_use_imm_q <= ex_use_imm_d;
            ex_rd_q      <= ex_rd_d;
            ex_rs1_q     <= ex_rs1_d;
            ex_rs2_q     <= ex_rs2_d;
            ex_imm_q     <= ex_imm_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            wb_ill_q     <= wb_ill_d;
            rf_q         <= rf_d;
        end
    end

    assign in_ready  = !stall;
    assign ret_valid = wb_valid_q;
    assign ret_rd    = wb_rd_q;
    assign ret_data  = wb_data_q;
    assign ret_ill   = wb_ill_q;
    assign dbg_data  = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe (default XLEN=32, NREGS=32); retirements are captured
// on the falling edge and compared against hand-computed values.
module tb_alu_exec_pipe;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic        in_use_imm;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        stall, flush;
    logic        ret_valid;
    logic [4:0]  ret_rd;
    logic [31:0] ret_data;
    logic        ret_ill;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int c0, c1;

    logic [4:0]  q_rd[$];
    logic [31:0] q_data[$];
    logic        q_ill[$];
    int          q_cyc[$];

    alu_exec_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_use_imm(in_use_imm), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .stall(stall), .flush(flush), .ret_valid(ret_valid),
        .ret_rd(ret_rd), .ret_data(ret_data), .ret_ill(ret_ill), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // A retirement counts on the coming edge only if that edge is not stalled.
    always @(negedge clk) begin
        if (!rst && ret_valid && !stall) begin
            q_rd.push_back(ret_rd);
            q_data.push_back(ret_data);
            q_ill.push_back(ret_ill);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic imm_sel, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        in_valid   = 1'b1;
        in_op      = op;
        in_use_imm = imm_sel;
        in_rd      = rd;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_imm     = imm;
        step();
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic expect_ret(input string tag, input logic [4:0] rd, input logic [31:0] data,
                              input logic ill, output int at);
        at = -1;
        check({tag, "_present"}, 64'(q_rd.size() != 0), 64'd1);
        if (q_rd.size() != 0) begin
            check({tag, "_rd"}, 64'(q_rd.pop_front()), 64'(rd));
            check({tag, "_data"}, 64'(q_data.pop_front()), 64'(data));
            check({tag, "_ill"}, 64'(q_ill.pop_front()), 64'(ill));
            at = q_cyc.pop_front();
        end
    endtask

    task automatic check_dbg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, 64'(dbg_data), 64'(exp));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_use_imm = 1'b0; in_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0; stall = 1'b0; flush = 1'b0; dbg_addr = '0;
        repeat (2) step();
        check("rst_ret_valid", 64'(ret_valid), 64'd0);
        check("rst_ret_rd", 64'(ret_rd), 64'd0);
        check("rst_ret_data", 64'(ret_data), 64'd0);
        check("rst_ret_ill", 64'(ret_ill), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check_dbg("rst_dbg_x1", 5'd1, 32'd0);
        rst = 1'b0;

        // 1: ADDI x1=5, x2=7
        issue(3'd0, 1'b1, 5'd1, 5'd0, 5'd0, 32'd5);
        issue(3'd0, 1'b1, 5'd2, 5'd0, 5'd0, 32'd7);
        drain(3);
        expect_ret("t1_x1", 5'd1, 32'd5, 1'b0, c0);
        expect_ret("t1_x2", 5'd2, 32'd7, 1'b0, c1);
        check_dbg("t1_dbg_x1", 5'd1, 32'd5);
        check_dbg("t1_dbg_x2", 5'd2, 32'd7);

        // 2: dependent back-to-back; SUB reads x3 from WB
        issue(3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
        issue(3'd1, 1'b0, 5'd4, 5'd3, 5'd1, 32'd0);
        drain(3);
        expect_ret("t2_x3", 5'd3, 32'd12, 1'b0, c0);
        expect_ret("t2_x4", 5'd4, 32'd7, 1'b0, c1);
        check("t2_no_bubble", 64'(c1 - c0), 64'd1);
        check_dbg("t2_dbg_x4", 5'd4, 32'd7);

        // 3: x0 retires its result but stays zero, and is never forwarded
        issue(3'd0, 1'b1, 5'd0, 5'd0, 5'd0, 32'd9);
        issue(3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'd0);
        drain(3);
        expect_ret("t3_x0", 5'd0, 32'd9, 1'b0, c0);
        expect_ret("t3_x5", 5'd5, 32'd0, 1'b0, c1);
        check_dbg("t3_dbg_x0", 5'd0, 32'd0);
        check_dbg("t3_dbg_x5", 5'd5, 32'd0);

        // 4: stall mid-stream
        issue(3'd0, 1'b1, 5'd7, 5'd0, 5'd0, 32'd1);
        issue(3'd0, 1'b1, 5'd8, 5'd0, 5'd0, 32'd2);
        stall = 1'b1;
        in_valid = 1'b1; in_rd = 5'd9; in_rs1 = 5'd0; in_imm = 32'd3;
        #1;
        check("t4_in_ready", 64'(in_ready), 64'd0);
        repeat (4) step();
        check("t4_hold_ret_rd", 64'(ret_rd), 64'd7);
        check_dbg("t4_rf_frozen_x7", 5'd7, 32'd0);
        stall = 1'b0;
        step();
        drain(3);
        expect_ret("t4_x7", 5'd7, 32'd1, 1'b0, c0);
        expect_ret("t4_x8", 5'd8, 32'd2, 1'b0, c1);
        expect_ret("t4_x9", 5'd9, 32'd3, 1'b0, c1);
        check("t4_count", 64'(q_rd.size()), 64'd0);
        check_dbg("t4_dbg_x9", 5'd9, 32'd3);

        // 5: flush the cycle after issue
        issue(3'd0, 1'b1, 5'd6, 5'd0, 5'd0, 32'd1);
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain(3);
        check("t5_no_retire", 64'(q_rd.size()), 64'd0);
        check_dbg("t5_dbg_x6", 5'd6, 32'd0);

        // 6: SRA of 0x80000000 by 4, operand bypassed from WB
        issue(3'd0, 1'b1, 5'd10, 5'd0, 5'd0, 32'h8000_0000);
        issue(3'd7, 1'b1, 5'd1, 5'd10, 5'd0, 32'd4);
        drain(3);
        expect_ret("t6_x10", 5'd10, 32'h8000_0000, 1'b0, c0);
`ifdef ALU_SHIFT_EN
        expect_ret("t6_sra", 5'd1, 32'hF800_0000, 1'b0, c1);
        check_dbg("t6_dbg_x1", 5'd1, 32'hF800_0000);
`else
        expect_ret("t6_sra", 5'd1, 32'd0, 1'b1, c1);
        check_dbg("t6_dbg_x1", 5'd1, 32'd5);
`endif
        check("t6_count", 64'(q_rd.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
